conv_window_sequencer: RTL and testbench

//  Sequences the convolution pointer array over a full output feature map.
//  Per output-window batch it loads the array base, issues K*K gated step pulses
//  (one per accepted memory read), then advances across columns and rows.

---
 rtl/conv_window_sequencer.sv | 164 ++++++++++++++++
 tb/tb_conv_window_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_sequencer.sv
// rtl/conv_window_sequencer.sv - walks the pointer array over an output feature map, one K*K read batch per window
module conv_window_sequencer #(
    parameter int N_UNITS = 16,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_start,
    input  logic               cfg_abort,
    input  logic [ADDR_W-1:0]  cfg_base_addr,
    input  logic [7:0]         cfg_kernel_size,
    input  logic [ADDR_W-1:0]  cfg_col_step,
    input  logic [ADDR_W-1:0]  cfg_row_step,
    input  logic [15:0]        cfg_out_cols,
    input  logic [15:0]        cfg_out_rows,
    input  logic [N_UNITS-1:0] cfg_active_units,
    output logic               ptr_load,
    output logic [ADDR_W-1:0]  ptr_start_addr,
    output logic [N_UNITS-1:0] ptr_active_units,
    output logic               ptr_step,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [15:0]        tap_idx,
    output logic [15:0]        win_col,
    output logic [15:0]        win_row,
    output logic               window_last,
    output logic               busy,
    output logic               done,
    output logic               err_cfg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_NEXT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0]  cur_addr, row_addr, col_step_q, row_step_q;
    logic [15:0]        kk_q, cols_q, rows_q, tap_q, col_q, row_q;
    logic [N_UNITS-1:0] mask_q;
    logic               err_q;

    logic cfg_bad, handshake, last_tap, last_col, last_row, leaving_run;

    assign cfg_bad   = (cfg_kernel_size == 8'd0) || (cfg_out_cols == 16'd0) ||
                       (cfg_out_rows == 16'd0) || (cfg_active_units == '0);
    assign handshake = (state == S_ISSUE) && rd_ready;
    assign last_tap  = (tap_q == kk_q - 16'd1);
    assign last_col  = (col_q == cols_q - 16'd1);
    assign last_row  = (row_q == rows_q - 16'd1);
    // Any return to IDLE (normal finish or abort) wipes the run context.
    assign leaving_run = (state != S_IDLE) && (state_nxt == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cfg_start && !cfg_bad) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_ISSUE;
            S_ISSUE: if (handshake && last_tap) state_nxt = S_NEXT;
            S_NEXT:  state_nxt = (last_col && last_row) ? S_DONE : S_LOAD;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (state != S_IDLE && cfg_abort) state_nxt = S_IDLE;
    end

    always_comb begin
        ptr_load         = (state == S_LOAD);
        rd_valid         = (state == S_ISSUE);
        ptr_step         = rd_valid && rd_ready;
        window_last      = rd_valid && rd_ready && last_tap;
        busy             = (state != S_IDLE);
        done             = (state == S_DONE);
        err_cfg          = err_q;
        ptr_start_addr   = cur_addr;
        ptr_active_units = mask_q;
        tap_idx          = tap_q;
        win_col          = col_q;
        win_row          = row_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr   <= '0;
            row_addr   <= '0;
            col_step_q <= '0;
            row_step_q <= '0;
            kk_q       <= '0;
            cols_q     <= '0;
            rows_q     <= '0;
            tap_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            mask_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (leaving_run) begin
                cur_addr   <= '0;
                row_addr   <= '0;
                col_step_q <= '0;
                row_step_q <= '0;
                kk_q       <= '0;
                cols_q     <= '0;
                rows_q     <= '0;
                tap_q      <= '0;
                col_q      <= '0;
                row_q      <= '0;
                mask_q     <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cfg_start && cfg_bad) begin
                            err_q <= 1'b1;
                        end else if (cfg_start) begin
                            cur_addr   <= cfg_base_addr;
                            row_addr   <= cfg_base_addr;
                            col_step_q <= cfg_col_step;
                            row_step_q <= cfg_row_step;
                            kk_q       <= {8'd0, cfg_kernel_size} * {8'd0, cfg_kernel_size};
                            cols_q     <= cfg_out_cols;
                            rows_q     <= cfg_out_rows;
                            mask_q     <= cfg_active_units;
                            tap_q      <= '0;
                            col_q      <= '0;
                            row_q      <= '0;
                        end
                    end
                    S_ISSUE: begin
                        if (rd_ready) tap_q <= last_tap ? 16'd0 : tap_q + 16'd1;
                    end
                    S_NEXT: begin
                        // Final window keeps its coordinates; DONE follows.
                        if (!(last_col && last_row)) begin
                            if (last_col) begin
                                col_q    <= '0;
                                row_q    <= row_q + 16'd1;
                                row_addr <= row_addr + row_step_q;
                                cur_addr <= row_addr + row_step_q;
                            end else begin
                                col_q    <= col_q + 16'd1;
                                cur_addr <= cur_addr + col_step_q;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb/tb_conv_window_sequencer.sv - scoreboard bench for conv_window_sequencer
module tb_conv_window_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start, cfg_abort;
    logic [31:0] cfg_base_addr, cfg_col_step, cfg_row_step;
    logic [7:0]  cfg_kernel_size;
    logic [15:0] cfg_out_cols, cfg_out_rows;
    logic [15:0] cfg_active_units;
    logic        ptr_load, ptr_step, rd_valid, rd_ready, window_last, busy, done, err_cfg;
    logic [31:0] ptr_start_addr;
    logic [15:0] ptr_active_units, tap_idx, win_col, win_row;

    conv_window_sequencer #(.N_UNITS(16), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_base_addr(cfg_base_addr), .cfg_kernel_size(cfg_kernel_size),
        .cfg_col_step(cfg_col_step), .cfg_row_step(cfg_row_step),
        .cfg_out_cols(cfg_out_cols), .cfg_out_rows(cfg_out_rows),
        .cfg_active_units(cfg_active_units), .ptr_load(ptr_load),
        .ptr_start_addr(ptr_start_addr), .ptr_active_units(ptr_active_units),
        .ptr_step(ptr_step), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .tap_idx(tap_idx), .win_col(win_col), .win_row(win_row),
        .window_last(window_last), .busy(busy), .done(done), .err_cfg(err_cfg)
    );

    always #5 clk = ~clk;

    localparam int K_LOAD = 0, K_DONE = 1, K_ERR = 2;
    typedef struct {
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0, errors = 0;
    int          step_cnt = 0, last_cnt = 0;
    int          exp_last_tap = 8;
    logic [15:0] exp_mask = 16'h0;
    int          rdy_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_expect(input int kind, input logic [31:0] val);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d val 0x%0h, expected none", kind, val);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_val", val, e.val);
        end
    endtask

    // rd_ready changes just after each rising edge so the monitor sees a stable value.
    initial begin
        rd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rd_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    initial begin
        logic pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend && !rd_valid) chk("rd_valid_held", rd_valid, 1'b1);
            if (ptr_load) begin
                pop_expect(K_LOAD, ptr_start_addr);
                chk("load_mask", ptr_active_units, exp_mask);
            end
            if (done)    pop_expect(K_DONE, 32'd0);
            if (err_cfg) pop_expect(K_ERR, 32'd0);
            if (ptr_step) step_cnt++;
            if (window_last) begin
                last_cnt++;
                chk("tap_at_last", tap_idx, exp_last_tap);
            end
            pend = rd_valid && !rd_ready && !cfg_abort && !rst;
        end
    end

    task automatic set_cfg(input logic [31:0] base, input logic [7:0] k, input logic [31:0] cs,
                           input logic [31:0] rs, input logic [15:0] cols, input logic [15:0] rows,
                           input logic [15:0] mask);
        cfg_base_addr = base; cfg_kernel_size = k; cfg_col_step = cs; cfg_row_step = rs;
        cfg_out_cols = cols; cfg_out_rows = rows; cfg_active_units = mask;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        tick();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    // cnt is the cycle index after the start edge (LOAD is cycle 1).
    task automatic wait_done(input int cnt0, input int exp_cyc, input string name);
        int cnt;
        cnt = cnt0;
        while (!done && cnt < 500) begin
            tick();
            cnt++;
        end
        if (exp_cyc > 0) chk(name, cnt, exp_cyc);
        else             chk(name, done, 1'b1);
        tick();
        chk({name, "_busy_after"}, busy, 1'b0);
    endtask

    task automatic push_t1();
        push(K_LOAD, 32'h100); push(K_LOAD, 32'h130);
        push(K_LOAD, 32'h500); push(K_LOAD, 32'h530);
        push(K_DONE, 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0;
        set_cfg(32'h100, 8'd3, 32'h30, 32'h400, 16'd2, 16'd2, 16'h00F3);
        exp_mask = 16'h00F3;
        repeat (3) tick();
        chk("rst_busy", busy, 0);          chk("rst_done", done, 0);
        chk("rst_ptr_load", ptr_load, 0);  chk("rst_rd_valid", rd_valid, 0);
        chk("rst_tap_idx", tap_idx, 0);    chk("rst_start_addr", ptr_start_addr, 0);
        chk("rst_mask", ptr_active_units, 0); chk("rst_err", err_cfg, 0);
        rst = 1'b0;
        tick();

        // 1: nominal 2x2 map, ready tied high
        step_cnt = 0; last_cnt = 0; exp_last_tap = 8;
        push_t1();
        start_pulse();
        chk("t1_load_latency", ptr_load, 1'b1);
        tick();
        chk("t1_rd_valid_latency", rd_valid, 1'b1);
        wait_done(2, 45, "t1_done_cycle");
        chk("t1_steps", step_cnt, 36);
        chk("t1_lasts", last_cnt, 4);
        chk("t1_queue_empty", exp_q.size(), 0);

        // 2: random backpressure
        step_cnt = 0; last_cnt = 0; rdy_mode = 1;
        push_t1();
        start_pulse();
        wait_done(1, 0, "t2_done");
        rdy_mode = 0;
        chk("t2_steps", step_cnt, 36);
        chk("t2_lasts", last_cnt, 4);
        chk("t2_queue_empty", exp_q.size(), 0);

        // 3: rejected configurations
        set_cfg(32'h100, 8'd0, 32'h30, 32'h400, 16'd2, 16'd2, 16'h00F3);
        push(K_ERR, 0);
        start_pulse();
        chk("t3_err_k0", err_cfg, 1'b1);
        chk("t3_busy_k0", busy, 1'b0);
        tick();
        chk("t3_err_one_cycle", err_cfg, 1'b0);
        set_cfg(32'h100, 8'd3, 32'h30, 32'h400, 16'd2, 16'd2, 16'h0000);
        push(K_ERR, 0);
        start_pulse();
        chk("t3_err_mask0", err_cfg, 1'b1);
        set_cfg(32'h100, 8'd3, 32'h30, 32'h400, 16'd0, 16'd2, 16'h00F3);
        push(K_ERR, 0);
        start_pulse();
        chk("t3_err_cols0", err_cfg, 1'b1);
        tick();
        chk("t3_busy_after", busy, 1'b0);
        chk("t3_queue_empty", exp_q.size(), 0);

        // 4: abort at tap 4 of batch 2, then clean restart
        set_cfg(32'h100, 8'd3, 32'h30, 32'h400, 16'd2, 16'd2, 16'h00F3);
        step_cnt = 0; last_cnt = 0;
        push(K_LOAD, 32'h100); push(K_LOAD, 32'h130);
        start_pulse();
        n = 0;
        while (!(rd_valid && win_col == 16'd1 && tap_idx == 16'd4) && n < 100) begin
            tick();
            n++;
        end
        chk("t4_reached_tap4", n < 100, 1'b1);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        chk("t4_busy", busy, 0);        chk("t4_rd_valid", rd_valid, 0);
        chk("t4_tap_idx", tap_idx, 0);  chk("t4_win_col", win_col, 0);
        chk("t4_steps", step_cnt, 14);
        repeat (3) tick();
        chk("t4_no_done_queue", exp_q.size(), 0);
        step_cnt = 0;
        push_t1();
        start_pulse();
        chk("t4_restart_col", win_col, 0);
        chk("t4_restart_row", win_row, 0);
        wait_done(1, 45, "t4_restart_done");
        chk("t4_restart_steps", step_cnt, 36);

        // 5: address wrap
        set_cfg(32'hFFFF_FFF0, 8'd1, 32'h20, 32'h0, 16'd2, 16'd1, 16'h00F3);
        exp_last_tap = 0;
        push(K_LOAD, 32'hFFFF_FFF0); push(K_LOAD, 32'h0000_0010); push(K_DONE, 0);
        start_pulse();
        wait_done(1, 7, "t5_done_cycle");
        chk("t5_queue_empty", exp_q.size(), 0);

        // 6: cfg changes and restarts while busy are ignored; rst mid-ISSUE clears all
        set_cfg(32'h100, 8'd3, 32'h30, 32'h400, 16'd2, 16'd2, 16'h00F3);
        exp_last_tap = 8;
        push_t1();
        start_pulse();
        repeat (4) tick();
        set_cfg(32'h7777, 8'd2, 32'h4, 32'h8, 16'd5, 16'd5, 16'hFFFF);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        wait_done(6, 45, "t6_done_cycle");
        chk("t6_queue_empty", exp_q.size(), 0);
        set_cfg(32'h100, 8'd3, 32'h30, 32'h400, 16'd2, 16'd2, 16'h00F3);
        push(K_LOAD, 32'h100);
        start_pulse();
        n = 0;
        while (!(rd_valid && tap_idx == 16'd2) && n < 100) begin
            tick();
            n++;
        end
        chk("t6_reached_issue", n < 100, 1'b1);
        rst = 1'b1;
        tick();
        chk("t6_rst_busy", busy, 0);       chk("t6_rst_rd_valid", rd_valid, 0);
        chk("t6_rst_ptr_step", ptr_step, 0); chk("t6_rst_tap", tap_idx, 0);
        chk("t6_rst_addr", ptr_start_addr, 0); chk("t6_rst_mask", ptr_active_units, 0);
        rst = 1'b0;
        repeat (2) tick();
        chk("t6_queue_empty_end", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
